stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes on every input and on the output, and a single registered output stage. Selection is either fixed by an external select or by round-robin arbitration among valid channels. Sits between multiple producer streams and one consumer, and is the successor to the combinational 16:1 bit mux.

## Interface
- N_CH, 16, number of input channels (2..64; need not be a power of two)
- W, 8, data width per channel
- SEL_W, $clog2(N_CH), select/channel-index width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  N_CH*W  channel i occupies bits [i*W +: W]
- in_valid  in  N_CH  per-channel valid
- in_ready  out  N_CH  per-channel ready (combinational)
- mode  in  1  0 = FIXED (use sel), 1 = RR (round-robin)
- sel  in  SEL_W  channel select in FIXED mode
- out_data  out  W  registered output data
- out_ch  out  SEL_W  index of channel that supplied out_data
- out_valid  out  1  registered output valid
- out_ready  in  1  consumer ready

## Operation
- Transfer on an input: in_valid[i] && in_ready[i]; on output: out_valid && out_ready.
- load = !out_valid || out_ready (stage empty or draining this cycle).
- Grant (combinational, at most one channel):
  - FIXED: g = sel if sel < N_CH and in_valid[sel]; otherwise none.
  - RR: g = first i with in_valid[i], scanning ptr, ptr+1, …, N_CH-1, 0, …, ptr-1; none if in_valid == 0.
- in_ready[i] = load && (g == i); all other in_ready bits 0. in_ready never depends on in_valid of other channels outside the grant logic.
- On load with a grant: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
- On load without a grant: out_valid <= 0; out_data/out_ch hold.
- Without load (stall): out_data, out_ch, out_valid hold.
- RR pointer ptr: on accepted input transfer in RR mode, ptr <= (g == N_CH-1) ? 0 : g+1. Wraps modulo N_CH (not 2^SEL_W). Unchanged in FIXED mode and when no transfer occurs.
- Mode or sel changes take effect on the next grant evaluation; never alter a held output word.
- sel >= N_CH: no grant, no in_ready, no error flag.

## Timing
- Reset (async assert, sync-safe deassert handled upstream): out_valid=0, out_data=0, out_ch=0, ptr=0; in_ready all 0 while rst_n low.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle with out_ready held high.
- Simultaneous drain and load: allowed in the same cycle; no bubble.
- Backpressure: out_ready low with out_valid high holds all outputs stable and forces all in_ready low.
- Reset mid-operation: held word is dropped; no input is acknowledged during reset.
- Combinational paths: out_ready -> in_ready, in_valid/sel/mode -> in_ready. No path to out_*.

## Structure
- Shared package: mode constants MODE_FIXED=1'b0, MODE_RR=1'b1.
- Sub-module rr_pick: rotating-base priority encoder, parameters N_CH, SEL_W; inputs req[N_CH], base[SEL_W]; outputs gnt_idx, gnt_vld. Used only in RR mode; FIXED path is a direct index compare.
- Top holds output register, ptr register, and in_ready decode.

## Test plan
- FIXED, N_CH=16, W=8: sel=5, in_data ch5=0xA5, in_valid=0x0020, out_ready=1 -> in_ready=0x0020, next cycle out_data=0xA5, out_ch=5, out_valid=1.
- RR fairness: all 16 valid, out_ready=1 for 18 cycles -> out_ch sequence 0,1,…,15,0,1; each in_ready one-hot in the same order.
- Backpressure: output holding 0x3C, out_ready=0 for 3 cycles while inputs valid -> out_data=0x3C stable, in_ready=0; out_ready=1 -> next word loaded in the same cycle the 0x3C drains.
- Non-power-of-two wrap, N_CH=3: valid=3'b101, RR -> out_ch 0,2,0,2; ptr never reaches 3.
- sel out of range, N_CH=12: sel=13, all valid -> in_ready=0, out_valid falls to 0 after the held word drains.
- Reset mid-stream: assert rst_n=0 while out_valid=1 -> out_valid=0, out_data=0, ptr=0 immediately; after release, RR restarts from channel 0.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// ============================================================================
// stream_mux_rr_pkg : shared selection-mode encoding for stream_mux_rr
// Rev 1.0
// ============================================================================
`default_nettype none

package stream_mux_rr_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

`default_nettype wire

// File: rtl/stream_mux_rr_if.sv
// ============================================================================
// stream_mux_rr_if : input streams, select controls and output stream bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface stream_mux_rr_if #(
  parameter int N_CH = 16,
  parameter int W    = 8
);
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_ready;
  logic              mode;
  logic [SEL_W-1:0]  sel;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_valid;
  logic              out_ready;

  // master: producers/consumer side; slave: the multiplexer
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/stream_mux_rr_rr_pick.sv
// ============================================================================
// rr_pick : rotating-base priority encoder, first request at or after base
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_CH  = 16,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] base,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [SEL_W:0] idx;

  // Scan offsets from farthest to nearest so the nearest request wins;
  // wrap is modulo N_CH, which need not be a power of two.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = {1'b0, base} + (SEL_W + 1)'(k);
      if (idx >= (SEL_W + 1)'(N_CH)) begin
        idx = idx - (SEL_W + 1)'(N_CH);
      end
      if (req[idx[SEL_W-1:0]]) begin
        gnt_idx = idx[SEL_W-1:0];
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_mux_rr.sv
// ============================================================================
// stream_mux_rr : N-channel stream mux, fixed or round-robin select, one reg stage
// Rev 1.0
// ============================================================================
`default_nettype none

module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int N_CH = 16,
  parameter int W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_mux_rr_if.slave  bus
);

  localparam int SEL_W = $clog2(N_CH);

  logic [W-1:0]     w_chan [N_CH];
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_idx, gnt_idx;
  logic             rr_vld, fix_vld, gnt_vld, load;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
      assign w_chan[i] = bus.in_data[i*W +: W];
    end
  endgenerate

  rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req     (bus.in_valid),
    .base    (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  // Out-of-range select simply never grants.
  assign fix_vld = ({1'b0, bus.sel} < (SEL_W + 1)'(N_CH)) && bus.in_valid[bus.sel];
  assign gnt_vld = (bus.mode == MODE_RR) ? rr_vld : fix_vld;
  assign gnt_idx = (bus.mode == MODE_RR) ? rr_idx : bus.sel;

  // Gating with rst_n keeps every in_ready low while reset is held.
  assign load = rst_n && (!out_valid_q || bus.out_ready);

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ready
      assign bus.in_ready[i] = load && gnt_vld && (gnt_idx == SEL_W'(i));
    end
  endgenerate

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (gnt_vld) begin
        out_data_d  = w_chan[gnt_idx];
        out_ch_d    = gnt_idx;
        out_valid_d = 1'b1;
        if (bus.mode == MODE_RR) begin
          ptr_d = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
// ============================================================================
// tb_stream_mux_rr : vector table, corner sequences and random run vs model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stream_mux_rr;
  import stream_mux_rr_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Three instances: 16, 3 and 12 channels; bench vectors padded to 16 channels.
  logic [127:0] tdat  [3];
  logic [15:0]  tvld  [3];
  logic         tmode [3];
  logic [3:0]   tsel  [3];
  logic         tordy [3];
  logic [15:0]  ardy  [3];
  logic [7:0]   adat  [3];
  logic [3:0]   ach   [3];
  logic         aval  [3];

  stream_mux_rr_if #(.N_CH(16), .W(8)) if16 ();
  stream_mux_rr_if #(.N_CH(3),  .W(8)) if3  ();
  stream_mux_rr_if #(.N_CH(12), .W(8)) if12 ();

  stream_mux_rr #(.N_CH(16), .W(8)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  stream_mux_rr #(.N_CH(3),  .W(8)) u3  (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  stream_mux_rr #(.N_CH(12), .W(8)) u12 (.clk(clk), .rst_n(rst_n), .bus(if12.slave));

  assign if16.in_data = tdat[0];        assign if3.in_data = tdat[1][23:0];  assign if12.in_data = tdat[2][95:0];
  assign if16.in_valid = tvld[0];       assign if3.in_valid = tvld[1][2:0];  assign if12.in_valid = tvld[2][11:0];
  assign if16.mode = tmode[0];          assign if3.mode = tmode[1];          assign if12.mode = tmode[2];
  assign if16.sel = tsel[0];            assign if3.sel = tsel[1][1:0];       assign if12.sel = tsel[2];
  assign if16.out_ready = tordy[0];     assign if3.out_ready = tordy[1];     assign if12.out_ready = tordy[2];
  assign ardy[0] = if16.in_ready;       assign ardy[1] = {13'b0, if3.in_ready}; assign ardy[2] = {4'b0, if12.in_ready};
  assign adat[0] = if16.out_data;       assign adat[1] = if3.out_data;       assign adat[2] = if12.out_data;
  assign ach[0] = if16.out_ch;          assign ach[1] = {2'b0, if3.out_ch};  assign ach[2] = if12.out_ch;
  assign aval[0] = if16.out_valid;      assign aval[1] = if3.out_valid;      assign aval[2] = if12.out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: held word plus a round-robin pointer per instance.
  int          NCH  [3] = '{16, 3, 12};
  int          SELW [3] = '{4, 2, 4};
  bit          m_vld [3];
  logic [7:0]  m_dat [3];
  int          m_ch  [3];
  int          m_ptr [3];

  task automatic mreset();
    for (int d = 0; d < 3; d++) begin
      m_vld[d] = 1'b0; m_dat[d] = 8'h00; m_ch[d] = 0; m_ptr[d] = 0;
    end
  endtask

  function automatic int grant(int d);
    int n = NCH[d];
    if (tmode[d] == MODE_FIXED) begin
      int s = int'(tsel[d]);
      return (s < n && tvld[d][s]) ? s : -1;
    end
    for (int k = 0; k < n; k++) begin
      int i = (m_ptr[d] + k) % n;
      if (tvld[d][i]) return i;
    end
    return -1;
  endfunction

  function automatic bit mload(int d);
    return rst_n && (!m_vld[d] || tordy[d]);
  endfunction

  function automatic logic [15:0] exp_ready(int d);
    logic [15:0] r = 16'h0;
    int g = grant(d);
    if (mload(d) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic mupdate(int d);
    int g = grant(d);
    if (!rst_n) begin
      m_vld[d] = 1'b0; m_dat[d] = 8'h00; m_ch[d] = 0; m_ptr[d] = 0;
    end else if (mload(d)) begin
      if (g >= 0) begin
        m_vld[d] = 1'b1;
        m_dat[d] = tdat[d][g*8 +: 8];
        m_ch[d]  = g;
        if (tmode[d] == MODE_RR) m_ptr[d] = (g + 1) % NCH[d];
      end else begin
        m_vld[d] = 1'b0;
      end
    end
  endtask

  // Inputs are driven at the falling edge; checks happen 1-2 units later.
  task automatic tick();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rdy%0d", d),  32'(ardy[d]), 32'(exp_ready(d)));
      chk($sformatf("ovld%0d", d), 32'(aval[d]), 32'(m_vld[d]));
      chk($sformatf("odat%0d", d), 32'(adat[d]), 32'(m_dat[d]));
      chk($sformatf("och%0d", d),  32'(ach[d]),  32'(m_ch[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) mupdate(d);
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      tvld[d] = 16'h0; tmode[d] = MODE_FIXED; tsel[d] = 4'd0; tordy[d] = 1'b1;
    end
  endtask

  typedef struct {
    logic        mode;
    logic [3:0]  sel;
    logic [15:0] vld;
    logic        ordy;
    logic [15:0] ready;
    logic        ovld;
    logic [3:0]  och;
    logic [7:0]  odat;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{MODE_FIXED, 4'd5,  16'h0020, 1'b1, 16'h0020, 1'b1, 4'd5,  8'hA5};
    tbl[1]  = '{MODE_FIXED, 4'd5,  16'h0000, 1'b1, 16'h0000, 1'b0, 4'd5,  8'hA5};
    tbl[2]  = '{MODE_FIXED, 4'd3,  16'h0020, 1'b1, 16'h0000, 1'b0, 4'd5,  8'hA5};
    tbl[3]  = '{MODE_FIXED, 4'd3,  16'h0008, 1'b1, 16'h0008, 1'b1, 4'd3,  8'hA3};
    tbl[4]  = '{MODE_FIXED, 4'd3,  16'h0008, 1'b0, 16'h0000, 1'b1, 4'd3,  8'hA3};
    tbl[5]  = '{MODE_FIXED, 4'd3,  16'h0008, 1'b1, 16'h0008, 1'b1, 4'd3,  8'hA3};
    tbl[6]  = '{MODE_RR,    4'd0,  16'hFFFF, 1'b1, 16'h0001, 1'b1, 4'd0,  8'hA0};
    tbl[7]  = '{MODE_RR,    4'd0,  16'h0001, 1'b1, 16'h0001, 1'b1, 4'd0,  8'hA0};
    tbl[8]  = '{MODE_RR,    4'd0,  16'h8004, 1'b1, 16'h0004, 1'b1, 4'd2,  8'hA2};
    tbl[9]  = '{MODE_RR,    4'd0,  16'h8004, 1'b1, 16'h8000, 1'b1, 4'd15, 8'hAF};
    tbl[10] = '{MODE_RR,    4'd0,  16'h8004, 1'b1, 16'h0004, 1'b1, 4'd2,  8'hA2};
    tbl[11] = '{MODE_FIXED, 4'd15, 16'h8000, 1'b0, 16'h0000, 1'b1, 4'd2,  8'hA2};

    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 16; i++) tdat[d][i*8 +: 8] = 8'hA0 + 8'(i);
    idle_all();
    mreset();

    // Reset with every channel requesting: nothing may be acknowledged.
    for (int d = 0; d < 3; d++) tvld[d] = 16'hFFFF;
    #1 rst_n = 1'b0;
    @(negedge clk);
    tick();
    chk("rst_ovld", 32'(aval[0]), 32'd0);
    chk("rst_odat", 32'(adat[0]), 32'd0);
    chk("rst_rdy",  32'(ardy[0]), 32'd0);
    rst_n = 1'b1;
    idle_all();

    for (int t = 0; t < 12; t++) begin
      tmode[0] = tbl[t].mode; tsel[0] = tbl[t].sel;
      tvld[0]  = tbl[t].vld;  tordy[0] = tbl[t].ordy;
      #1;
      chk($sformatf("tbl%0d_rdy", t), 32'(ardy[0]), 32'(tbl[t].ready));
      tick();
      chk($sformatf("tbl%0d_ovld", t), 32'(aval[0]), 32'(tbl[t].ovld));
      chk($sformatf("tbl%0d_och", t),  32'(ach[0]),  32'(tbl[t].och));
      chk($sformatf("tbl%0d_odat", t), 32'(adat[0]), 32'(tbl[t].odat));
    end

    // Fresh start for the multi-cycle corner sequences.
    idle_all();
    rst_n = 1'b0;
    #1 mreset();
    tick();
    rst_n = 1'b1;

    for (int k = 0; k < 18; k++) begin
      tmode[0] = MODE_RR; tvld[0] = 16'hFFFF;
      tmode[1] = MODE_RR; tvld[1] = (k < 4) ? 16'h0005 : 16'h0000;
      tmode[2] = MODE_FIXED; tvld[2] = 16'h0FFF; tsel[2] = (k == 0) ? 4'd4 : 4'd13;
      #1;
      chk("rr16_rdy", 32'(ardy[0]), 32'(16'h1 << (k % 16)));
      if (k < 4) chk("rr3_rdy", 32'(ardy[1]), (k % 2 == 1) ? 32'h4 : 32'h1);
      if (k >= 1) chk("sel13_rdy", 32'(ardy[2]), 32'd0);
      tick();
      chk("rr16_ch", 32'(ach[0]), 32'(k % 16));
      chk("rr16_vld", 32'(aval[0]), 32'd1);
      if (k < 4) chk("rr3_ch", 32'(ach[1]), (k % 2 == 1) ? 32'd2 : 32'd0);
      chk("sel13_vld", 32'(aval[2]), (k == 0) ? 32'd1 : 32'd0);
    end

    // Backpressure: hold 0x3C three cycles, then drain and reload together.
    idle_all();
    tmode[0] = MODE_FIXED; tsel[0] = 4'd7; tvld[0] = 16'h0080;
    tdat[0][7*8 +: 8] = 8'h3C;
    tick();
    chk("bp_load", 32'(adat[0]), 32'h3C);
    tdat[0][7*8 +: 8] = 8'h5A;
    tordy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_rdy", 32'(ardy[0]), 32'd0);
      tick();
      chk("bp_hold", 32'(adat[0]), 32'h3C);
      chk("bp_vld", 32'(aval[0]), 32'd1);
    end
    tordy[0] = 1'b1;
    #1 chk("bp_release_rdy", 32'(ardy[0]), 32'h0080);
    tick();
    chk("bp_next", 32'(adat[0]), 32'h5A);
    tdat[0][7*8 +: 8] = 8'hA7;

    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 3; d++) begin
        tmode[d] = $urandom_range(0, 1) == 1 ? MODE_RR : MODE_FIXED;
        tsel[d]  = 4'($urandom_range(0, (1 << SELW[d]) - 1));
        tvld[d]  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        tordy[d] = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 16; i++) tdat[d][i*8 +: 8] = 8'($urandom);
      end
      tick();
    end

    // Reset mid-stream with a word held and the pointer advanced.
    idle_all();
    tmode[0] = MODE_RR; tvld[0] = 16'hFFFF;
    tick();
    tordy[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovld", 32'(aval[0]), 32'd0);
    chk("mid_rst_odat", 32'(adat[0]), 32'd0);
    chk("mid_rst_och",  32'(ach[0]),  32'd0);
    chk("mid_rst_rdy",  32'(ardy[0]), 32'd0);
    mreset();
    tick();
    rst_n = 1'b1;
    tordy[0] = 1'b1;
    #1 chk("post_rst_rdy", 32'(ardy[0]), 32'h1);
    tick();
    chk("post_rst_ch", 32'(ach[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
